// File: rtl/wb_pwm_pkg.sv
// Shared register map, control/status bit positions and bus helpers for wb_pwm.
// Imported by the top-level and by pwm_channel.
package wb_pwm_pkg;

  // Register offsets, expressed as word indices (byte offset >> 2)
  localparam logic [3:0] REG_CTRL     = 4'h0;
  localparam logic [3:0] REG_PRESCALE = 4'h1;
  localparam logic [3:0] REG_PERIOD   = 4'h2;
  localparam logic [3:0] REG_STATUS   = 4'h3;
  localparam logic [3:0] REG_DUTY0    = 4'h4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_INV_LSB = 8;

  localparam int STATUS_WRAP  = 0;

  // Expand the four byte enables into a per-bit write mask.
  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_pwm_channel.sv
// One PWM channel: double-buffered duty register, compare against the shared
// period counter, optional inversion and a registered output.
module pwm_channel
  import wb_pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wdat_i,
  input  logic [CNT_W-1:0] wmask_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             invert_i,
  output logic [CNT_W-1:0] shadow_o,
  output logic             pwm_o
);

  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] active_q;
  logic             pwm_q, pwm_d;
  logic             raw;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_i) shadow_d = (shadow_q & ~wmask_i) | (wdat_i & wmask_i);
    raw   = en_i & (cnt_i < active_q);
    pwm_d = en_i ? (raw ^ invert_i) : invert_i;
  end

  // The active copy takes the newest shadow value, so a write landing on the
  // load edge is not lost for a whole extra period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (load_i) active_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign shadow_o = shadow_q;
  assign pwm_o    = pwm_q;

endmodule

// File: rtl/wb_pwm.sv
// Wishbone classic PWM generator: register decode, shared prescaler and period
// counter, wrap status/interrupt, and CHANNELS duty-compare outputs.
module wb_pwm
  import wb_pwm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  input  logic                wb_we_i,
  output logic                wb_ack_o,
  output logic                intr,
  output logic [CHANNELS-1:0] pwm_o
);

  logic [15:0]         ctrl_q, ctrl_d;
  logic [CNT_W-1:0]    prescale_q, prescale_d;
  logic [CNT_W-1:0]    period_sh_q, period_sh_d, period_act_q;
  logic [CNT_W-1:0]    pcnt_q, pcnt_d, cnt_q, cnt_d;
  logic                wrap_flag_q, wrap_flag_d;
  logic                ack_q;
  logic [31:0]         dat_q, dat_d, rdata;
  logic                access, wr, w1c;
  logic                en_q, en_d, tick, wrap_ev, load_act;
  logic [3:0]          reg_idx;
  logic [31:0]         mask32;
  logic [CNT_W-1:0]    wmask, wdat;
  logic [CNT_W-1:0]    duty_sh [CHANNELS];
  logic [CHANNELS-1:0] duty_wr;
  logic                unused_bits;

  assign access  = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr      = access & wb_we_i;
  assign reg_idx = wb_adr_i[5:2];
  assign mask32  = sel_mask(wb_sel_i);
  assign wmask   = mask32[CNT_W-1:0];
  assign wdat    = wb_dat_i[CNT_W-1:0];
  assign w1c     = wr & (reg_idx == REG_STATUS) & wb_sel_i[0] & wb_dat_i[STATUS_WRAP];
  assign unused_bits = ^{wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i, mask32};

  always_comb begin
    ctrl_d      = ctrl_q;
    prescale_d  = prescale_q;
    period_sh_d = period_sh_q;
    if (wr && reg_idx == REG_CTRL)
      ctrl_d = (ctrl_q & ~mask32[15:0]) | (wb_dat_i[15:0] & mask32[15:0]);
    if (wr && reg_idx == REG_PRESCALE)
      prescale_d = (prescale_q & ~wmask) | (wdat & wmask);
    if (wr && reg_idx == REG_PERIOD)
      period_sh_d = (period_sh_q & ~wmask) | (wdat & wmask);
  end

  assign en_q     = ctrl_q[CTRL_EN];
  assign en_d     = ctrl_d[CTRL_EN];
  // >= keeps the prescaler from running the long way round if PRESCALE shrinks mid-count
  assign tick     = en_q & (pcnt_q >= prescale_q);
  assign wrap_ev  = tick & (cnt_q == period_act_q);
  assign load_act = ~en_q | wrap_ev;

  always_comb begin
    pcnt_d = '0;
    cnt_d  = '0;
    if (en_q && en_d) begin
      pcnt_d = tick ? '0 : pcnt_q + CNT_W'(1);
      cnt_d  = cnt_q;
      if (wrap_ev)   cnt_d = '0;
      else if (tick) cnt_d = cnt_q + CNT_W'(1);
    end
    wrap_flag_d = wrap_ev | (wrap_flag_q & ~w1c);
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_CTRL:     rdata = 32'(ctrl_q);
      REG_PRESCALE: rdata = 32'(prescale_q);
      REG_PERIOD:   rdata = 32'(period_sh_q);
      REG_STATUS:   rdata[STATUS_WRAP] = wrap_flag_q;
      default: begin
        for (int n = 0; n < CHANNELS; n++)
          if (reg_idx == REG_DUTY0 + 4'(n)) rdata = 32'(duty_sh[n]);
      end
    endcase
    dat_d = (access && !wb_we_i) ? rdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q       <= '0;
      prescale_q   <= '0;
      period_sh_q  <= '0;
      period_act_q <= '0;
      pcnt_q       <= '0;
      cnt_q        <= '0;
      wrap_flag_q  <= 1'b0;
      ack_q        <= 1'b0;
      dat_q        <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      prescale_q  <= prescale_d;
      period_sh_q <= period_sh_d;
      if (load_act) period_act_q <= period_sh_d;
      pcnt_q      <= pcnt_d;
      cnt_q       <= cnt_d;
      wrap_flag_q <= wrap_flag_d;
      ack_q       <= access;
      dat_q       <= dat_d;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign duty_wr[gi] = wr & (reg_idx == REG_DUTY0 + 4'(gi));
      pwm_channel #(.CNT_W(CNT_W)) u_ch (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en_q),
        .load_i   (load_act),
        .wr_i     (duty_wr[gi]),
        .wdat_i   (wdat),
        .wmask_i  (wmask),
        .cnt_i    (cnt_q),
        .invert_i (ctrl_q[CTRL_INV_LSB + gi]),
        .shadow_o (duty_sh[gi]),
        .pwm_o    (pwm_o[gi])
      );
    end
  endgenerate

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign intr     = wrap_flag_q & ctrl_q[CTRL_IRQ_EN];

endmodule
